tt_um_count_checker: RTL and testbench

- Sequence monitor that is the receiving end of the team's 8-bit programmable counter.
- Samples an externally driven 8-bit count value on a strobe and checks that each sample equals the previous sample +1.
- Counts mismatches and reports lock/fault status.
- Sits in the same TinyTapeout tile template and is intended to be wired to the counter's uo_out for bring-up and self-test.

---
 rtl/tt_um_count_checker.sv | 158 +++++++++++++++
 tb/tb_tt_um_count_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_count_checker.sv
`timescale 1ns/1ps
// Receive-side sequence monitor for the 8-bit counter: checks each strobed sample is previous+1.
// Capture lands on the 3rd clk edge after a strobe rise; no backpressure, a strobe seen while ena=0 is lost.
module tt_um_count_checker #(
  parameter int MISS_LIMIT = 3,
  parameter int GOOD_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);
  localparam logic [3:0] GOOD_LIM = 4'(GOOD_LIMIT);

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync3_q, sync3_d;
  logic [7:0] sample_q, sample_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] miss_run_q, miss_run_d;
  logic [3:0] good_run_q, good_run_d;
  logic       last_mis_q, last_mis_d;

  logic       strobe_in;
  logic       resync;
  logic       mode;
  logic       view;
  logic       strb_edge;
  logic       match;
  logic [7:0] exp_val;
  logic [7:0] err_inc;
  logic [3:0] miss_inc;
  logic [3:0] good_inc;
  logic       unused_ok;

  assign strobe_in = uio_in[0];
  assign resync    = uio_in[1];
  assign mode      = uio_in[2];
  assign view      = uio_in[3];
  assign unused_ok = &{1'b0, uio_in[7:4]};

  assign strb_edge = sync2_q & ~sync3_q;
  assign exp_val   = sample_q + 8'd1;
  assign match     = (ui_in == exp_val) || (mode && (ui_in == sample_q));
  assign err_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign miss_inc  = miss_run_q + 4'd1;
  assign good_inc  = good_run_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      sample_q   <= 8'd0;
      err_cnt_q  <= 8'd0;
      miss_run_q <= 4'd0;
      good_run_q <= 4'd0;
      last_mis_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      sample_q   <= sample_d;
      err_cnt_q  <= err_cnt_d;
      miss_run_q <= miss_run_d;
      good_run_q <= good_run_d;
      last_mis_q <= last_mis_d;
    end
  end

  always_comb begin
    // The strobe synchroniser free-runs so an edge during ena=0 is consumed, not queued.
    sync1_d    = strobe_in;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    state_d    = state_q;
    sample_d   = sample_q;
    err_cnt_d  = err_cnt_q;
    miss_run_d = miss_run_q;
    good_run_d = good_run_q;
    last_mis_d = last_mis_q;
    if (ena) begin
      if (resync) begin
        state_d    = IDLE;
        sample_d   = 8'd0;
        err_cnt_d  = 8'd0;
        miss_run_d = 4'd0;
        good_run_d = 4'd0;
        last_mis_d = 1'b0;
      end else if (strb_edge) begin
        sample_d = ui_in;
        case (state_q)
          IDLE: begin
            state_d    = TRACK;
            last_mis_d = 1'b0;
          end
          TRACK: begin
            if (match) begin
              miss_run_d = 4'd0;
              last_mis_d = 1'b0;
            end else begin
              err_cnt_d  = err_inc;
              miss_run_d = miss_inc;
              last_mis_d = 1'b1;
              if (miss_inc == MISS_LIM) begin
                state_d    = FAULT;
                good_run_d = 4'd0;
              end
            end
          end
          FAULT: begin
            if (match) begin
              good_run_d = good_inc;
              last_mis_d = 1'b0;
              if (good_inc == GOOD_LIM) begin
                state_d    = TRACK;
                miss_run_d = 4'd0;
              end
            end else begin
              err_cnt_d  = err_inc;
              good_run_d = 4'd0;
              last_mis_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    uo_out  = view ? err_cnt_q : sample_q;
    uio_out = {last_mis_q, (err_cnt_q == 8'hFF), (state_q == FAULT), (state_q == TRACK), 4'b0000};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_count_checker.sv
`timescale 1ns/1ps
// Bench for tt_um_count_checker: vector table through a scoreboard queue plus hand-written corner sequences.
module tb_tt_um_count_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic       strobe = 1'b0;
  logic       resync = 1'b0;
  logic       mode = 1'b0;
  logic       view = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {4'b0000, view, mode, resync, strobe};

  tt_um_count_checker #(.MISS_LIMIT(3), .GOOD_LIMIT(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sample;
    logic [7:0] err;
    logic [7:0] uio;
  } exp_t;

  typedef struct {
    bit         rs;
    logic       mode;
    logic [7:0] val;
    logic [7:0] es;
    logic [7:0] ee;
    logic [7:0] eu;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t last;
  exp_t e;
  vec_t vecs[21];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", nm, act, expv);
    end
  endtask

  // Call #1 after a posedge: checks both views and status within the high phase.
  task automatic check_out(input string nm, input exp_t x);
    view = 1'b0;
    #1 chk({nm, ".sample"}, uo_out, x.sample);
    view = 1'b1;
    #1 chk({nm, ".err"}, uo_out, x.err);
    chk({nm, ".uio"}, uio_out, x.uio);
    view = 1'b0;
  endtask

  task automatic cap(input logic [7:0] val, input logic m, input bit lat);
    @(negedge clk);
    ui_in  = val;
    mode   = m;
    strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    if (lat) begin
      #1 chk("latency.sample_held", uo_out, last.sample);
      chk("latency.uio_held", uio_out, last.uio);
    end
    @(posedge clk);
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_resync();
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    last = '{8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'h10, 8'h10, 8'h00, 8'h10};
    vecs[1]  = '{1'b0, 1'b0, 8'h11, 8'h11, 8'h00, 8'h10};
    vecs[2]  = '{1'b0, 1'b0, 8'h12, 8'h12, 8'h00, 8'h10};
    vecs[3]  = '{1'b1, 1'b0, 8'hFE, 8'hFE, 8'h00, 8'h10};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h10};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h10};
    vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 8'h10};
    vecs[7]  = '{1'b1, 1'b0, 8'h20, 8'h20, 8'h00, 8'h10};
    vecs[8]  = '{1'b0, 1'b0, 8'h22, 8'h22, 8'h01, 8'h90};
    vecs[9]  = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h02, 8'h90};
    vecs[10] = '{1'b0, 1'b0, 8'h40, 8'h40, 8'h03, 8'hA0};
    vecs[11] = '{1'b0, 1'b0, 8'h41, 8'h41, 8'h03, 8'h20};
    vecs[12] = '{1'b0, 1'b0, 8'h42, 8'h42, 8'h03, 8'h20};
    vecs[13] = '{1'b0, 1'b0, 8'h43, 8'h43, 8'h03, 8'h20};
    vecs[14] = '{1'b0, 1'b0, 8'h44, 8'h44, 8'h03, 8'h10};
    vecs[15] = '{1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 8'h10};
    vecs[16] = '{1'b0, 1'b1, 8'h05, 8'h05, 8'h00, 8'h10};
    vecs[17] = '{1'b0, 1'b1, 8'h06, 8'h06, 8'h00, 8'h10};
    vecs[18] = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 8'h10};
    vecs[19] = '{1'b0, 1'b0, 8'h05, 8'h05, 8'h01, 8'h90};
    vecs[20] = '{1'b0, 1'b0, 8'h06, 8'h06, 8'h01, 8'h10};

    last = '{8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1 check_out("reset", '{8'h00, 8'h00, 8'h00});
    chk("reset.uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].rs) do_resync();
      sb.push_back('{vecs[i].es, vecs[i].ee, vecs[i].eu});
      cap(vecs[i].val, vecs[i].mode, 1'b1);
      e = sb.pop_front();
      @(posedge clk);
      check_out($sformatf("vec%0d", i), e);
      last = e;
    end

    // Saturation: 0x00 repeatedly never matches in strict mode.
    do_resync();
    cap(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) cap(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    check_out("sat255", '{8'h00, 8'hFF, 8'hE0});
    cap(8'h00, 1'b0, 1'b0);
    @(posedge clk);
    check_out("sat256", '{8'h00, 8'hFF, 8'hE0});
    do_resync();
    @(posedge clk);
    check_out("sat_resync", '{8'h00, 8'h00, 8'h00});

    // Strobe while ena=0 is lost, not replayed once ena returns.
    cap(8'h00, 1'b0, 1'b0);
    cap(8'h01, 1'b0, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    cap(8'h50, 1'b0, 1'b0);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    check_out("ena_off", '{8'h01, 8'h00, 8'h10});
    cap(8'h02, 1'b0, 1'b0);
    @(posedge clk);
    check_out("ena_back", '{8'h02, 8'h00, 8'h10});

    // Resync on the capture edge drops the capture.
    @(negedge clk);
    ui_in  = 8'h60;
    strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    strobe = 1'b0;
    @(posedge clk);
    check_out("resync_drop", '{8'h00, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    cap(8'h77, 1'b0, 1'b0);
    @(posedge clk);
    check_out("after_drop", '{8'h77, 8'h00, 8'h10});
    cap(8'h10, 1'b0, 1'b0);
    @(posedge clk);
    check_out("pre_reset", '{8'h10, 8'h01, 8'h90});

    // Asynchronous reset mid-cycle, strobe held high through release.
    @(posedge clk);
    #1 rst_n = 1'b0;
    ui_in  = 8'h33;
    strobe = 1'b1;
    check_out("async_reset", '{8'h00, 8'h00, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_out("strobe_thru_reset", '{8'h33, 8'h00, 8'h10});
    ui_in = 8'h99;
    repeat (6) @(posedge clk);
    check_out("single_capture", '{8'h33, 8'h00, 8'h10});
    strobe = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
